stream_serializer: RTL and testbench
====================================

# stream_serializer

Transmit end of the one-bit serial link whose receivers take a single data bit `i` per clock. Accepts WIDTH-bit words on a valid/ready stream input and shifts each out LSB-first on a 1-bit serial output, followed by an even-parity bit. Output is framed by valid/last strobes and paced by a downstream stall input. Sits between a TDF stream producer and any serial consumer in the design.

## Interface

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  word to transmit; sampled on accept.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle; accept = in_valid & in_ready at the rising edge.
- ser_o  output  1  serial bit.
- ser_valid  output  1  ser_o carries a frame bit this cycle.
- ser_last  output  1  current bit is the parity (final) bit of the frame.
- ser_stall  input  1  downstream cannot take the bit; the current bit holds.

## Operation

- Registers: state {IDLE, DATA, PARITY}; shift register WIDTH bits; bit counter ceil(log2(WIDTH)) bits; parity accumulator 1 bit.
- IDLE: ser_valid=0, ser_o=0, ser_last=0. On accept: shift<=in_data, count<=0, par<=0, ->DATA.
- DATA: ser_o=shift[0], ser_valid=1, ser_last=0. If !ser_stall: par<=par^shift[0], shift<=shift>>1, count<=count+1; when count==WIDTH-1 ->PARITY. If ser_stall: all registers hold.
- PARITY: ser_o=par (XOR of all WIDTH data bits, i.e. even parity), ser_valid=1, ser_last=1. If ser_stall: hold. Else if accept: load new word, ->DATA (zero-gap back-to-back). Else ->IDLE.
- in_ready = reset & ((state==IDLE) | (state==PARITY & !ser_stall)). Combinational from state and ser_stall only; never depends on in_valid.
- ser_stall is ignored in IDLE.
- in_data changes while not accepted have no effect.
- Outputs ser_o/ser_valid/ser_last decode only from registers (glitch-free w.r.t. inputs).
- No latches: every combinational signal is assigned on every path.

## Timing

- Reset (reset=0, asynchronous): state=IDLE, shift=0, count=0, par=0; ser_o=0, ser_valid=0, ser_last=0, in_ready=0 immediately, independent of clock.
- First edge after reset release: in_ready=1.
- Latency: word accepted at edge N -> bit 0 on ser_o during cycle N+1 (after edge N).
- Unstalled frame: WIDTH data cycles + 1 parity cycle = WIDTH+1 cycles of ser_valid.
- Each ser_stall cycle while ser_valid=1 extends the frame by exactly one cycle; the bit is repeated, never skipped or duplicated downstream.
- Back-to-back: with in_valid held, frames are contiguous; ser_valid never drops between parity of frame k and bit 0 of frame k+1.
- Stall on the parity bit blocks in_ready that cycle; accept occurs on the first unstalled parity cycle.
- Reset mid-frame: frame abandoned; no residual bits after release.

## Test plan

- Reset: hold reset=0 for 3 clocks with in_valid=1 -> ser_valid=ser_o=ser_last=in_ready=0 throughout; one clock after release in_ready=1, ser_valid=0.
- Single word 0xA5 (WIDTH=8), no stall -> ser_o over 9 cycles = 1,0,1,0,0,1,0,1 then parity 0; ser_last=1 only on cycle 9; then IDLE, ser_valid=0.
- Word 0x01 -> bits 1,0,0,0,0,0,0,0, parity 1; word 0x00 -> nine 0 bits, parity 0, ser_valid=1 for all 9.
- Back-to-back 0xFF then 0x00, in_valid held -> 18 contiguous ser_valid cycles; parity bits 0 and 0; in_ready=1 exactly on the two parity-or-idle accept cycles.
- Stall: 0xA5, ser_stall=1 for 3 cycles while bit 3 (0) shown, then 2 cycles on parity -> ser_o holds each; frame length 14 cycles; in_ready=0 during parity stall, accepts on first unstalled parity cycle.
- Reset mid-frame: assert reset during bit 5 of 0xA5 -> outputs 0 without clock edge; after release and no new in_valid, ser_valid stays 0.

Source files
------------

// File: rtl/stream_serializer.sv
// Word-to-serial transmitter: shifts each accepted WIDTH-bit word out LSB-first,
// then appends an even-parity bit flagged with ser_last.
module stream_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_o,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic             par_q, par_d;
  logic             accept;

  // Handshake: a word moves when in_valid and in_ready are both high at the
  // rising edge. in_ready depends only on state, ser_stall and reset, never on
  // in_valid; a stalled parity bit withholds in_ready so frames never overlap.
  assign in_ready = reset & ((state_q == IDLE) | ((state_q == PARITY) & ~ser_stall));
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    count_d = count_q;
    par_d   = par_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = in_data;
          count_d = '0;
          par_d   = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!ser_stall) begin
          par_d   = par_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          count_d = count_q + 1'b1;
          if (count_q == LAST_BIT) state_d = PARITY;
        end
      end
      PARITY: begin
        if (!ser_stall) begin
          if (accept) begin
            shift_d = in_data;
            count_d = '0;
            par_d   = 1'b0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs decode from registers only, so input glitches never reach them.
  always_comb begin
    ser_o     = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    case (state_q)
      DATA: begin
        ser_o     = shift_q[0];
        ser_valid = 1'b1;
      end
      PARITY: begin
        ser_o     = par_q;
        ser_valid = 1'b1;
        ser_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer (WIDTH=8): per-cycle vector table plus
// hand-written reset sequences.
module tb_stream_serializer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       ser_o;
  logic       ser_valid;
  logic       ser_last;
  logic       ser_stall;

  int checks = 0;
  int errors = 0;

  stream_serializer #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_o     (ser_o),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .ser_stall (ser_stall)
  );

  always #5 clock = ~clock;

  // One record per clock cycle: inputs driven, then outputs expected in that cycle.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       st;
    logic       rdy;
    logic       o;
    logic       vl;
    logic       ls;
  } vec_t;

  vec_t vq[$];

  function automatic void row(input logic v, input logic [7:0] d, input logic st,
                              input logic rdy, input logic o, input logic vl, input logic ls);
    vec_t r;
    r.v = v; r.d = d; r.st = st; r.rdy = rdy; r.o = o; r.vl = vl; r.ls = ls;
    vq.push_back(r);
  endfunction

  // Unstalled frame: eight data rows (LSB first) and one parity row; in_valid/in_data
  // are held at hv/hd throughout, so an accept can only happen on the parity row.
  function automatic void frame_rows(input logic [7:0] word, input logic par,
                                     input logic hv, input logic [7:0] hd);
    for (int i = 0; i < 8; i++) row(hv, hd, 1'b0, 1'b0, word[i], 1'b1, 1'b0);
    row(hv, hd, 1'b0, 1'b1, par, 1'b1, 1'b1);
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic o,
                         input logic vl, input logic ls);
    chk({tag, " in_ready"}, in_ready, rdy);
    chk({tag, " ser_o"}, ser_o, o);
    chk({tag, " ser_valid"}, ser_valid, vl);
    chk({tag, " ser_last"}, ser_last, ls);
  endtask

  task automatic apply(input vec_t r, input int idx);
    in_valid  = r.v;
    in_data   = r.d;
    ser_stall = r.st;
    #2;
    chk_all($sformatf("row%0d", idx), r.rdy, r.o, r.vl, r.ls);
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset held with in_valid asserted: everything stays quiet.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    ser_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk_all($sformatf("reset_hold%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    chk_all("after_release", 1'b1, 1'b0, 1'b0, 1'b0);

    // Single 0xA5: bits 1,0,1,0,0,1,0,1 then parity 0.
    row(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_rows(8'hA5, 1'b0, 1'b0, 8'h00);
    row(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // 0x01 (parity 1) then 0x00 (parity 0) as separate frames.
    row(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_rows(8'h01, 1'b1, 1'b0, 8'h00);
    row(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_rows(8'h00, 1'b0, 1'b0, 8'h5A);
    row(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Back-to-back 0xFF then 0x00 with in_valid held: 18 contiguous valid cycles.
    row(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    frame_rows(8'hFF, 1'b0, 1'b1, 8'h00);
    frame_rows(8'h00, 1'b0, 1'b0, 8'h00);
    row(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Stall: ignored in IDLE; 3 stalls on bit 3, 2 stalls on parity, then accept 0x01.
    row(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    row(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    row(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    row(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    frame_rows(8'h01, 1'b1, 1'b0, 8'h00);
    row(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Reset mid-frame: accept 0xA5, advance to bit 5, then reset between edges.
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    ser_stall = 1'b0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
    end
    chk_all("midframe_bit5", 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk_all("midframe_async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      chk_all($sformatf("post_reset%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
